// File: rtl/csr_mmode.sv
// csr_mmode: RISC-V machine-mode CSR file with trap entry and mret handling.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters and their shadows.
module csr_mmode #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100,
    parameter int unsigned HART_ID  = 0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            mie_out
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] IRQ_EN_MASK = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~(XLEN'(3));

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] irq_en_q, irq_en_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

    logic [XLEN-1:0] mstatus_rd_c;
    logic [XLEN-1:0] old_c;
    logic [XLEN-1:0] wval_c;
    logic            hit_c;
    logic            ro_c;
    logic            wr_req_c;
    logic            wr_en_c;

`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam bit          IS_RV32     = (XLEN == 32);

    logic [63:0] cycle_q, cycle_d, cycle_inc_c;
    logic [63:0] instret_q, instret_d, instret_inc_c;
`else
    logic unused_retire;
    assign unused_retire = instr_retire;
`endif

    // mstatus view: only MIE/MPIE are stored, MPP is hardwired to M-mode
    always_comb begin
        mstatus_rd_c        = '0;
        mstatus_rd_c[12:11] = 2'b11;
        mstatus_rd_c[7]     = mpie_q;
        mstatus_rd_c[3]     = mie_q;
    end

    // Address decode: old value, implemented and read-only flags
    always_comb begin
        old_c = '0;
        hit_c = 1'b1;
        ro_c  = 1'b0;
        case (csr_addr)
            A_MSTATUS:   old_c = mstatus_rd_c;
            A_MISA:      old_c = XLEN'(MISA_VAL);
            A_MIE:       old_c = irq_en_q;
            A_MTVEC:     old_c = mtvec_q;
            A_MSCRATCH:  old_c = mscratch_q;
            A_MEPC:      old_c = mepc_q;
            A_MCAUSE:    old_c = mcause_q;
            A_MTVAL:     old_c = mtval_q;
            A_MIP:       old_c = '0;
            A_MVENDORID, A_MARCHID, A_MIMPID: ro_c = 1'b1;
            A_MHARTID: begin
                old_c = XLEN'(HART_ID);
                ro_c  = 1'b1;
            end
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    old_c = cycle_q[XLEN-1:0];
            A_MINSTRET:  old_c = instret_q[XLEN-1:0];
            A_CYCLE: begin
                old_c = cycle_q[XLEN-1:0];
                ro_c  = 1'b1;
            end
            A_INSTRET: begin
                old_c = instret_q[XLEN-1:0];
                ro_c  = 1'b1;
            end
            A_MCYCLEH, A_CYCLEH: begin
                if (IS_RV32) old_c = XLEN'(cycle_q[63:32]);
                else         hit_c = 1'b0;
                ro_c = (csr_addr == A_CYCLEH);
            end
            A_MINSTRETH, A_INSTRETH: begin
                if (IS_RV32) old_c = XLEN'(instret_q[63:32]);
                else         hit_c = 1'b0;
                ro_c = (csr_addr == A_INSTRETH);
            end
`endif
            default:     hit_c = 1'b0;
        endcase
    end

    // Read-modify-write value for the requested operation
    always_comb begin
        case (csr_op)
            OP_RW:   wval_c = csr_wdata;
            OP_RS:   wval_c = old_c | csr_wdata;
            OP_RC:   wval_c = old_c & ~csr_wdata;
            default: wval_c = old_c;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never counts as a write
    assign wr_req_c    = (csr_op == OP_RW) || ((csr_op != OP_NONE) && (csr_wdata != '0));
    assign csr_illegal = (csr_op != OP_NONE) && (!hit_c || (ro_c && wr_req_c));
    assign csr_rdata   = old_c;
    assign wr_en_c     = wr_req_c && !csr_illegal && !trap_valid && !mret;

    // Trap entry beats mret, which beats a software CSR write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        irq_en_d   = irq_en_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & ALIGN_MASK;
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en_c) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = wval_c[3];
                    mpie_d = wval_c[7];
                end
                A_MIE:      irq_en_d   = wval_c & IRQ_EN_MASK;
                A_MTVEC:    mtvec_d    = wval_c & ALIGN_MASK;
                A_MSCRATCH: mscratch_d = wval_c;
                A_MEPC:     mepc_d     = wval_c & ALIGN_MASK;
                A_MCAUSE:   mcause_d   = wval_c;
                A_MTVAL:    mtval_d    = wval_c;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            irq_en_q   <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            irq_en_q   <= irq_en_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A written half takes the new value and receives no increment or carry
    always_comb begin
        cycle_inc_c   = cycle_q + 64'd1;
        instret_inc_c = instret_q + 64'(instr_retire);
        cycle_d       = cycle_inc_c;
        instret_d     = instret_inc_c;
        if (wr_en_c) begin
            case (csr_addr)
                A_MCYCLE: begin
                    if (IS_RV32) cycle_d = {cycle_q[63:32], wval_c[31:0]};
                    else         cycle_d = 64'(wval_c);
                end
                A_MCYCLEH: begin
                    if (IS_RV32) cycle_d = {wval_c[31:0], cycle_inc_c[31:0]};
                end
                A_MINSTRET: begin
                    if (IS_RV32) instret_d = {instret_q[63:32], wval_c[31:0]};
                    else         instret_d = 64'(wval_c);
                end
                A_MINSTRETH: begin
                    if (IS_RV32) instret_d = {wval_c[31:0], instret_inc_c[31:0]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end
`endif

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_mmode.sv
// tb_csr_mmode: vector table plus hand-written sequences for csr_mmode (XLEN=32, HART_ID=3).
`timescale 1ns/1ps
module tb_csr_mmode;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret;
    logic [31:0] mtvec_out, mepc_out;
    logic        mie_out;

    always #5 clk = ~clk;

    csr_mmode #(.XLEN(32), .MISA_VAL(32'h4000_0100), .HART_ID(3)) dut (
        .clk(clk), .resetn(resetn), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
    );

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic        tv;
        logic        mr;
        logic [31:0] tpc, tcause, ttval;
        logic [31:0] e_rdata;
        logic        e_ill;
        logic [31:0] e_mtvec, e_mepc;
        logic        e_mie;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        ill;
        logic [31:0] mtvec, mepc;
        logic        mie;
    } exp_t;

    localparam int NV = 34;
    vec_t vecs[NV];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input logic [11:0] a, input logic [1:0] o, input logic [31:0] wd,
                                input logic tv, input logic mr, input logic [31:0] tpc,
                                input logic [31:0] tc, input logic [31:0] tt,
                                input logic [31:0] er, input logic ei,
                                input logic [31:0] emt, input logic [31:0] emp, input logic emi);
        vec_t v;
        v.addr = a; v.op = o; v.wdata = wd; v.tv = tv; v.mr = mr;
        v.tpc = tpc; v.tcause = tc; v.ttval = tt;
        v.e_rdata = er; v.e_ill = ei; v.e_mtvec = emt; v.e_mepc = emp; v.e_mie = emi;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = '0;
        instr_retire = 1'b0; trap_valid = 1'b0; mret = 1'b0;
        trap_cause = '0; trap_pc = '0; trap_tval = '0;
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [1:0] o, input logic [31:0] wd);
        csr_addr = a; csr_op = o; csr_wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
        set_csr(a, 2'b00, '0);
        #1;
        check(nm, 64'(csr_rdata), 64'(exp));
    endtask

    task automatic chk_ill(input string nm, input logic [11:0] a, input logic [1:0] o,
                           input logic [31:0] wd, input logic exp);
        set_csr(a, o, wd);
        #1;
        check(nm, 64'(csr_illegal), 64'(exp));
        set_csr(a, 2'b00, '0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        resetn = 1'b0;

        vecs[0]  = mk(12'hF14, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h3,        0, 32'h0,    32'h0,        0);
        vecs[1]  = mk(12'hF14, 2'd1, 32'h5,        0, 0, 0, 0, 0, 32'h3,        1, 32'h0,    32'h0,        0);
        vecs[2]  = mk(12'hF14, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h3,        0, 32'h0,    32'h0,        0);
        vecs[3]  = mk(12'h305, 2'd1, 32'h1003,     0, 0, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        0);
        vecs[4]  = mk(12'h305, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h1000,     0, 32'h1000, 32'h0,        0);
        vecs[5]  = mk(12'h300, 2'd0, 32'h0,        0, 1, 0, 0, 0, 32'h1800,     0, 32'h1000, 32'h0,        0);
        vecs[6]  = mk(12'h300, 2'd2, 32'h8,        0, 0, 0, 0, 0, 32'h1880,     0, 32'h1000, 32'h0,        0);
        vecs[7]  = mk(12'h300, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h1888,     0, 32'h1000, 32'h0,        1);
        vecs[8]  = mk(12'h341, 2'd0, 32'h0,        1, 0, 32'h206, 32'hB, 32'h55, 32'h0, 0, 32'h1000, 32'h0,     1);
        vecs[9]  = mk(12'h341, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h204,      0, 32'h1000, 32'h204,      0);
        vecs[10] = mk(12'h342, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'hB,        0, 32'h1000, 32'h204,      0);
        vecs[11] = mk(12'h343, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h55,       0, 32'h1000, 32'h204,      0);
        vecs[12] = mk(12'h300, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h1880,     0, 32'h1000, 32'h204,      0);
        vecs[13] = mk(12'h300, 2'd0, 32'h0,        0, 1, 0, 0, 0, 32'h1880,     0, 32'h1000, 32'h204,      0);
        vecs[14] = mk(12'h300, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h1888,     0, 32'h1000, 32'h204,      1);
        vecs[15] = mk(12'h340, 2'd1, 32'hAA,       1, 1, 32'h300, 32'h7, 32'h99, 32'h0, 0, 32'h1000, 32'h204,   1);
        vecs[16] = mk(12'h340, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h1000, 32'h300,      0);
        vecs[17] = mk(12'h342, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h7,        0, 32'h1000, 32'h300,      0);
        vecs[18] = mk(12'h344, 2'd1, 32'hFFFF,     0, 0, 0, 0, 0, 32'h0,        0, 32'h1000, 32'h300,      0);
        vecs[19] = mk(12'h344, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h1000, 32'h300,      0);
        vecs[20] = mk(12'h301, 2'd1, 32'h0,        0, 0, 0, 0, 0, 32'h4000_0100, 0, 32'h1000, 32'h300,     0);
        vecs[21] = mk(12'h301, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h4000_0100, 0, 32'h1000, 32'h300,     0);
        vecs[22] = mk(12'h7C0, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h1000, 32'h300,      0);
        vecs[23] = mk(12'h7C0, 2'd2, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 32'h1000, 32'h300,      0);
        vecs[24] = mk(12'h304, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0,       0, 32'h1000, 32'h300,      0);
        vecs[25] = mk(12'h304, 2'd3, 32'h8,        0, 0, 0, 0, 0, 32'h888,      0, 32'h1000, 32'h300,      0);
        vecs[26] = mk(12'h304, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h880,      0, 32'h1000, 32'h300,      0);
        vecs[27] = mk(12'h300, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h1880,    0, 32'h1000, 32'h300,      0);
        vecs[28] = mk(12'h300, 2'd3, 32'h88,       0, 0, 0, 0, 0, 32'h1888,     0, 32'h1000, 32'h300,      1);
        vecs[29] = mk(12'h300, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'h1800,     0, 32'h1000, 32'h300,      0);
        vecs[30] = mk(12'hF11, 2'd2, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 32'h1000, 32'h300,      0);
        vecs[31] = mk(12'hF12, 2'd3, 32'h1,        0, 0, 0, 0, 0, 32'h0,        1, 32'h1000, 32'h300,      0);
        vecs[32] = mk(12'h341, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h300,     0, 32'h1000, 32'h300,      0);
        vecs[33] = mk(12'h341, 2'd0, 32'h0,        0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h1000, 32'hFFFF_FFFC, 0);

        // Reset state and release between edges
        repeat (2) @(posedge clk);
        #3;
        check("rst_mtvec", 64'(mtvec_out), 64'h0);
        check("rst_mepc", 64'(mepc_out), 64'h0);
        check("rst_mie", 64'(mie_out), 64'h0);
        resetn = 1'b1;
`ifdef CSR_COUNTERS_EN
        rd("cycle_at_release", 12'hC00, 32'h0);
        tick();
        rd("cycle_first_edge", 12'hB00, 32'h1);
`else
        tick();
`endif

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            set_csr(vecs[i].addr, vecs[i].op, vecs[i].wdata);
            trap_valid = vecs[i].tv; mret = vecs[i].mr;
            trap_pc = vecs[i].tpc; trap_cause = vecs[i].tcause; trap_tval = vecs[i].ttval;
            sb.push_back('{i, vecs[i].e_rdata, vecs[i].e_ill, vecs[i].e_mtvec, vecs[i].e_mepc, vecs[i].e_mie});
            #2;
            e = sb.pop_front();
            check($sformatf("row%0d_rdata", e.idx), 64'(csr_rdata), 64'(e.rdata));
            check($sformatf("row%0d_illegal", e.idx), 64'(csr_illegal), 64'(e.ill));
            check($sformatf("row%0d_mtvec", e.idx), 64'(mtvec_out), 64'(e.mtvec));
            check($sformatf("row%0d_mepc", e.idx), 64'(mepc_out), 64'(e.mepc));
            check($sformatf("row%0d_mie", e.idx), 64'(mie_out), 64'(e.mie));
            tick();
        end
        idle();

`ifdef CSR_COUNTERS_EN
        // Low-half write then carry into the high half
        set_csr(12'hB80, 2'd1, 32'h7); tick();
        set_csr(12'hB00, 2'd1, 32'hFFFF_FFFF); tick();
        rd("cyc_lo_written", 12'hC00, 32'hFFFF_FFFF);
        rd("cyc_hi_kept", 12'hC80, 32'h7);
        tick();
        rd("cyc_lo_wrapped", 12'hC00, 32'h0);
        rd("cyc_hi_carry", 12'hC80, 32'h8);
        rd("mcycleh_carry", 12'hB80, 32'h8);
        chk_ill("cycle_shadow_rw", 12'hC00, 2'd1, 32'h0, 1'b1);
        chk_ill("mcycle_rw_legal", 12'hB00, 2'd1, 32'h0, 1'b0);
        // Full 64-bit wrap
        set_csr(12'hB80, 2'd1, 32'hFFFF_FFFF); tick();
        set_csr(12'hB00, 2'd1, 32'hFFFF_FFFF); tick();
        rd("cyc_max_lo", 12'hC00, 32'hFFFF_FFFF);
        rd("cyc_max_hi", 12'hC80, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap_lo", 12'hC00, 32'h0);
        rd("cyc_wrap_hi", 12'hC80, 32'h0);
        tick();
        // Trap drops the counter write in the same cycle
        set_csr(12'hB00, 2'd1, 32'h100);
        trap_valid = 1'b1; trap_pc = 32'h40; trap_cause = 32'h2; trap_tval = 32'h0;
        tick();
        idle();
        rd("cyc_write_dropped", 12'hC00, 32'h2);
        // Retire counting
        rd("instret_start", 12'hC02, 32'h0);
        instr_retire = 1'b1;
        repeat (5) tick();
        instr_retire = 1'b0;
        rd("instret_5", 12'hC02, 32'h5);
        rd("minstret_5", 12'hB02, 32'h5);
        rd("instreth_0", 12'hC82, 32'h0);
`else
        rd("no_cnt_b00_rd", 12'hB00, 32'h0);
        rd("no_cnt_c02_rd", 12'hC02, 32'h0);
        chk_ill("no_cnt_b00_rs0", 12'hB00, 2'd2, 32'h0, 1'b1);
        chk_ill("no_cnt_c80_rd", 12'hC80, 2'd3, 32'h0, 1'b1);
        chk_ill("no_cnt_b82_rw", 12'hB82, 2'd1, 32'h1, 1'b1);
        chk_ill("no_cnt_c00_op0", 12'hC00, 2'd0, 32'h0, 1'b0);
        tick();
`endif

        // Asynchronous reset with live state, no clock edge in between
        set_csr(12'h300, 2'd2, 32'h8); tick();
        set_csr(12'h340, 2'd1, 32'h5A5A); tick();
        rd("pre_rst_mscratch", 12'h340, 32'h5A5A);
        check("pre_rst_mie", 64'(mie_out), 64'h1);
        resetn = 1'b0;
        #1;
        check("arst_mie", 64'(mie_out), 64'h0);
        check("arst_mtvec", 64'(mtvec_out), 64'h0);
        check("arst_mepc", 64'(mepc_out), 64'h0);
        rd("arst_mstatus", 12'h300, 32'h1800);
        rd("arst_mscratch", 12'h340, 32'h0);
`ifdef CSR_COUNTERS_EN
        rd("arst_cycle", 12'hC00, 32'h0);
        rd("arst_instret", 12'hC02, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
